// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

   // Transmitter states; the current state names the bit being driven on the line.
   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } tx_state_e;

   // Line levels.
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Encoding of par_type_in.
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = ~PAR_EVEN;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one serial bit per rising edge of the divided bit clock.
// Frame = start, DATA_WIDTH data bits (LSB first), optional parity, stop.
// Build option: define UART_TX_PARITY_EN to include the parity bit; without it
// par_en_in/par_type_in are ignored and every frame is 2 + DATA_WIDTH bits long.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] tx_data_in,
   input  logic                  tx_valid_in,
   output logic                  tx_ready_out,
   input  logic                  par_en_in,
   input  logic                  par_type_in,
   output logic                  tx_out,
   output logic                  busy_out
);

   localparam int unsigned      CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   tx_state_e             r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_tx;
   logic                  r_busy;
   logic                  w_ready;
   logic                  w_accept;

`ifdef UART_TX_PARITY_EN
   logic r_par_en;
   logic r_par_bit;
`else
   // Parity inputs are kept on the port list but have no function in this build.
   logic w_unused_par;
   assign w_unused_par = par_en_in ^ par_type_in;
`endif

   // Ready while idle or while the stop bit is out, so frames can run back to back.
   assign w_ready  = (r_state == StIdle) || (r_state == StStop);
   assign w_accept = tx_valid_in && w_ready;

   // Frame sequencer; tx_out and busy_out are registered alongside the state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StIdle;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_tx      <= IDLE_LEVEL;
         r_busy    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle, StStop: begin
               if (w_accept) begin
                  r_state   <= StStart;
                  r_tx      <= START_BIT;
                  r_busy    <= 1'b1;
                  r_shift   <= tx_data_in;
                  r_cnt     <= '0;
`ifdef UART_TX_PARITY_EN
                  r_par_en  <= par_en_in;
                  r_par_bit <= (^tx_data_in) ^ (par_type_in == PAR_ODD);
`endif
               end else begin
                  r_state <= StIdle;
                  r_tx    <= IDLE_LEVEL;
                  r_busy  <= 1'b0;
               end
            end
            StStart: begin
               r_state <= StData;
               r_tx    <= r_shift[0];
               r_shift <= r_shift >> 1;
            end
            StData: begin
               if (r_cnt == CNT_LAST) begin
                  r_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                  if (r_par_en) begin
                     r_state <= StParity;
                     r_tx    <= r_par_bit;
                  end else begin
                     r_state <= StStop;
                     r_tx    <= STOP_BIT;
                     r_busy  <= 1'b0;
                  end
`else
                  r_state <= StStop;
                  r_tx    <= STOP_BIT;
                  r_busy  <= 1'b0;
`endif
               end else begin
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_tx    <= r_shift[0];
                  r_shift <= r_shift >> 1;
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
               r_state <= StStop;
               r_tx    <= STOP_BIT;
               r_busy  <= 1'b0;
            end
`endif
            default: begin
               r_state <= StIdle;
               r_tx    <= IDLE_LEVEL;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign tx_ready_out = w_ready;
   assign tx_out       = r_tx;
   assign busy_out     = r_busy;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed frames plus random streams,
// compared against a frame-level model of the serial line.
module tb_uart_tx_serializer;
   import uart_pkg::*;

   localparam int unsigned DW = 8;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR_BUILD = 1'b1;
`else
   localparam bit PAR_BUILD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [DW-1:0] tx_data_in;
   logic          tx_valid_in;
   logic          tx_ready_out;
   logic          par_en_in;
   logic          par_type_in;
   logic          tx_out;
   logic          busy_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(.DATA_WIDTH(DW)) dut (
      .clk          (clk),
      .reset        (reset),
      .tx_data_in   (tx_data_in),
      .tx_valid_in  (tx_valid_in),
      .tx_ready_out (tx_ready_out),
      .par_en_in    (par_en_in),
      .par_type_in  (par_type_in),
      .tx_out       (tx_out),
      .busy_out     (busy_out)
   );

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Frame length in line cycles.
   function automatic int frame_len(input bit pen);
      return 2 + DW + ((PAR_BUILD && pen) ? 1 : 0);
   endfunction

   // Expected line level for bit i of a frame.
   function automatic logic exp_bit(input logic [DW-1:0] d, input bit pen, input bit pty,
                                    input int i);
      bit has_par;
      bit odd_ones;
      has_par  = PAR_BUILD && pen;
      odd_ones = ($countones(d) % 2) == 1;
      if (i == 0) return 1'b0;
      if (i <= DW) return d[i-1];
      // Even parity makes the total count of ones even; odd parity makes it odd.
      if (has_par && i == DW + 1) return pty ? !odd_ones : odd_ones;
      return 1'b1;
   endfunction

   // Call at a negedge with the word presented and tx_valid_in high.
   task automatic run_frame(input logic [DW-1:0] d, input bit pen, input bit pty,
                            input bit chain, input logic [DW-1:0] nd, input bit npen,
                            input bit npty);
      int len;
      len = frame_len(pen);
      @(posedge clk);
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (chain) begin
            tx_data_in  = nd;
            par_en_in   = npen;
            par_type_in = npty;
            tx_valid_in = 1'b1;
         end else begin
            // Stray request and churning inputs mid-frame must not disturb the frame.
            tx_valid_in = (i == 1);
            tx_data_in  = DW'($urandom);
            par_en_in   = 1'($urandom);
            par_type_in = 1'($urandom);
         end
         check($sformatf("tx d=%h bit%0d", d, i), tx_out, exp_bit(d, pen, pty, i));
         check($sformatf("busy d=%h bit%0d", d, i), busy_out, logic'(i != len - 1));
         check($sformatf("ready d=%h bit%0d", d, i), tx_ready_out, logic'(i == len - 1));
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      tx_valid_in = 1'b0;
      check({tag, " tx"}, tx_out, 1'b1);
      check({tag, " ready"}, tx_ready_out, 1'b1);
      check({tag, " busy"}, busy_out, 1'b0);
   endtask

   task automatic present(input logic [DW-1:0] d, input bit pen, input bit pty);
      tx_data_in  = d;
      par_en_in   = pen;
      par_type_in = pty;
      tx_valid_in = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] cur_d, nxt_d;
      bit            cur_pen, cur_pty, nxt_pen, nxt_pty, chain;

      reset       = 1'b1;
      tx_data_in  = '0;
      tx_valid_in = 1'b0;
      par_en_in   = 1'b0;
      par_type_in = 1'b0;
      repeat (3) @(negedge clk);
      check("reset tx", tx_out, 1'b1);
      check("reset ready", tx_ready_out, 1'b1);
      check("reset busy", busy_out, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 20; i++) check_idle("idle");

      // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1.
      present(8'hA5, 1'b0, PAR_EVEN);
      run_frame(8'hA5, 1'b0, PAR_EVEN, 1'b0, '0, 1'b0, 1'b0);
      check_idle("after A5");

      // 0xA5 with even then odd parity.
      @(negedge clk);
      present(8'hA5, 1'b1, PAR_EVEN);
      run_frame(8'hA5, 1'b1, PAR_EVEN, 1'b0, '0, 1'b0, 1'b0);
      check_idle("after A5 even");
      @(negedge clk);
      present(8'hA5, 1'b1, PAR_ODD);
      run_frame(8'hA5, 1'b1, PAR_ODD, 1'b0, '0, 1'b0, 1'b0);
      check_idle("after A5 odd");

      // Back to back: 0x01 then 0xFF with valid held high.
      @(negedge clk);
      present(8'h01, 1'b0, PAR_EVEN);
      run_frame(8'h01, 1'b0, PAR_EVEN, 1'b1, 8'hFF, 1'b0, PAR_EVEN);
      run_frame(8'hFF, 1'b0, PAR_EVEN, 1'b0, '0, 1'b0, 1'b0);
      check_idle("after FF");

      // Reset during the 4th data bit.
      @(negedge clk);
      present(8'hC3, 1'b1, PAR_ODD);
      @(posedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tx_valid_in = 1'b0;
         check($sformatf("pre-reset bit%0d", i), tx_out, exp_bit(8'hC3, 1'b1, PAR_ODD, i));
      end
      #1 reset = 1'b1;
      #1;
      check("midreset tx", tx_out, 1'b1);
      check("midreset busy", busy_out, 1'b0);
      check("midreset ready", tx_ready_out, 1'b1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_idle("post reset");
      @(negedge clk);
      present(8'h3C, 1'b0, PAR_EVEN);
      run_frame(8'h3C, 1'b0, PAR_EVEN, 1'b0, '0, 1'b0, 1'b0);
      check_idle("after 3C");

      // 0x5A with parity requested: 11 cycles in a parity build, 10 otherwise.
      @(negedge clk);
      present(8'h5A, 1'b1, PAR_EVEN);
      run_frame(8'h5A, 1'b1, PAR_EVEN, 1'b0, '0, 1'b0, 1'b0);
      check_idle("after 5A");

      // Random words, parity settings and chaining.
      @(negedge clk);
      cur_d   = DW'($urandom);
      cur_pen = 1'($urandom);
      cur_pty = 1'($urandom);
      present(cur_d, cur_pen, cur_pty);
      for (int n = 0; n < 24; n++) begin
         nxt_d   = DW'($urandom);
         nxt_pen = 1'($urandom);
         nxt_pty = 1'($urandom);
         chain   = (n < 23) && (1'($urandom) == 1'b1);
         run_frame(cur_d, cur_pen, cur_pty, chain, nxt_d, nxt_pen, nxt_pty);
         if (!chain) begin
            check_idle("rand gap");
            if (n < 23) begin
               @(negedge clk);
               present(nxt_d, nxt_pen, nxt_pty);
            end
         end
         cur_d   = nxt_d;
         cur_pen = nxt_pen;
         cur_pty = nxt_pty;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
